// File: rtl/spi_master_ctrl.sv
// Byte-wide SPI master behind the SPI_COMMAND/SPI_CSR window.
// Owns SPI_CSR bit 0 (BUSY) and returns the received byte.
// IDLE  | sck follows CPOL, waiting for trigger
// SETUP | first half period before edge 1 (edge 1 issued on its last cycle)
// SHIFT | edges 2..16, one per half period
// HOLD  | last half period with sck back at CPOL
// DONE  | one cycle: response valid, done pulse
module spi_master_ctrl #(
  parameter int CLK_DIV   = 2,
  parameter int DIV_SEL_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:1] spi_csr_in,
  output logic       spi_busy,
  input  logic       spi_trigger,
  input  logic [7:0] spi_command,
  output logic [7:0] spi_response,
  output logic       spi_done,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam int H_MAX = CLK_DIV << ((1 << DIV_SEL_W) - 1);
  localparam int TW    = $clog2(H_MAX + 1);
  localparam logic [TW-1:0] CLK_DIV_W = TW'(CLK_DIV);
  localparam logic [TW-1:0] ONE_W     = TW'(1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, half_q, half_sel;
  logic [4:0]           edge_q, edge_nxt;
  logic [7:0]           tx_q, rx_q, resp_q;
  logic                 cpha_q, sck_q, cs_q;
  logic                 start, tc, active, edge_go, tx_shift_en, rx_sample_en;
  logic [DIV_SEL_W-1:0] div_sel;
  logic                 unused_rsvd;

  assign unused_rsvd = ^spi_csr_in[7:6];
  assign div_sel     = spi_csr_in[4 +: DIV_SEL_W];
  assign half_sel    = CLK_DIV_W << div_sel;

  assign start    = (state_q == IDLE) && spi_trigger;
  assign tc       = (timer_q == '0);
  assign active   = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign edge_go  = tc && ((state_q == SETUP) || (state_q == SHIFT));
  assign edge_nxt = edge_q + 5'd1;

  // CPHA=0 samples on odd edges and shifts on even; CPHA=1 the reverse,
  // with bit 7 already presented from the trigger so the first shift is edge 3.
  assign rx_sample_en = edge_go && (edge_nxt[0] != cpha_q);
  assign tx_shift_en  = edge_go && (cpha_q ? (edge_nxt[0] && edge_nxt >= 5'd3)
                                           : (!edge_nxt[0] && edge_nxt < 5'd16));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = SETUP;
      SETUP: if (tc) state_d = SHIFT;
      SHIFT: if (tc && edge_nxt == 5'd16) state_d = HOLD;
      HOLD:  if (tc) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      half_q  <= CLK_DIV_W;
      edge_q  <= '0;
      cpha_q  <= 1'b0;
    end else if (start) begin
      timer_q <= half_sel - ONE_W;
      half_q  <= half_sel;
      edge_q  <= '0;
      cpha_q  <= spi_csr_in[3];
    end else if (active) begin
      timer_q <= tc ? (half_q - ONE_W) : (timer_q - ONE_W);
      if (edge_go) edge_q <= edge_nxt;
    end
  end

  // CPOL is captured through sck itself: it tracks spi_csr_in[1] in IDLE,
  // including the trigger cycle, and only toggles afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sck_q <= 1'b0;
    else if (state_q == IDLE)  sck_q <= spi_csr_in[1];
    else if (edge_go)          sck_q <= ~sck_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= '0;
      rx_q   <= '0;
      resp_q <= '0;
    end else begin
      if (start)             tx_q <= spi_command;
      else if (tx_shift_en)  tx_q <= {tx_q[6:0], 1'b0};
      if (rx_sample_en)      rx_q <= {rx_q[6:0], miso};
      if (state_d == DONE)   resp_q <= rx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs_q <= 1'b1;
    else        cs_q <= spi_csr_in[2];
  end

  assign spi_busy     = active;
  assign spi_done     = (state_q == DONE);
  assign spi_response = resp_q;
  assign sck          = sck_q;
  assign mosi         = active ? tx_q[7] : 1'b0;
  assign cs_n         = cs_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: modes, divider, busy triggers, reset, chip select.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:1] csr;
  logic       trig;
  logic [7:0] cmd;
  logic       miso, loop_en, miso_val;
  logic       spi_busy, spi_done, sck, mosi, cs_n;
  logic [7:0] spi_response;

  int tests = 0;
  int fails = 0;

  spi_master_ctrl #(.CLK_DIV(2), .DIV_SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_csr_in(csr), .spi_busy(spi_busy),
    .spi_trigger(trig), .spi_command(cmd), .spi_response(spi_response),
    .spi_done(spi_done), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;
  assign miso = loop_en ? mosi : miso_val;

  int cyc = 0, busy_cnt = 0, done_cnt = 0, tog_cnt = 0, rise_cnt = 0;
  int last_tog = 0, gap = 0;
  logic sck_prev = 1'b0;
  logic [15:0] mosi_log = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (spi_busy) busy_cnt = busy_cnt + 1;
    if (spi_done) done_cnt = done_cnt + 1;
    if (sck !== sck_prev) begin
      tog_cnt  = tog_cnt + 1;
      gap      = cyc - last_tog;
      last_tog = cyc;
      if (sck) begin
        rise_cnt = rise_cnt + 1;
        mosi_log = {mosi_log[14:0], mosi};
      end
    end
    sck_prev = sck;
  end

  int b0, d0, t0, r0;

  task automatic snap();
    b0 = busy_cnt; d0 = done_cnt; t0 = tog_cnt; r0 = rise_cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [7:0] b);
    trig = 1'b1;
    cmd  = b;
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!spi_done && n < 2000) begin
      tick();
      n++;
    end
    chk("done_seen", {31'd0, spi_done}, 32'd1);
  endtask

  initial begin
    csr = 7'b0; csr[2] = 1'b1;
    trig = 1'b0; cmd = 8'h00; loop_en = 1'b0; miso_val = 1'b0;

    #12;
    chk("rst_busy", {31'd0, spi_busy}, 0);
    chk("rst_resp", {24'd0, spi_response}, 0);
    chk("rst_done", {31'd0, spi_done}, 0);
    chk("rst_sck",  {31'd0, sck}, 0);
    chk("rst_mosi", {31'd0, mosi}, 0);
    chk("rst_cs_n", {31'd0, cs_n}, 1);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // Mode 0, H=2, loopback
    loop_en = 1'b1;
    snap();
    start_xfer(8'hA5);
    wait_done();
    chk("m0_resp", {24'd0, spi_response}, 32'hA5);
    tick();
    chk("m0_rises", rise_cnt - r0, 8);
    chk("m0_mosi_seq", {24'd0, mosi_log[7:0]}, 32'hA5);
    chk("m0_busy_cycles", busy_cnt - b0, 34);
    chk("m0_done_pulses", done_cnt - d0, 1);
    chk("m0_half_period", gap, 2);

    // CPOL=1, CPHA=1, miso tied high
    csr[1] = 1'b1; csr[3] = 1'b1;
    loop_en = 1'b0; miso_val = 1'b1;
    tick(); tick();
    chk("m3_sck_idle_before", {31'd0, sck}, 1);
    snap();
    start_xfer(8'h3C);
    wait_done();
    chk("m3_resp", {24'd0, spi_response}, 32'hFF);
    tick();
    chk("m3_toggles", tog_cnt - t0, 16);
    chk("m3_sck_idle_after", {31'd0, sck}, 1);

    // DIV_SEL=3, mode 0, miso tied low
    csr[1] = 1'b0; csr[3] = 1'b0; csr[5:4] = 2'b11;
    miso_val = 1'b0;
    tick(); tick();
    snap();
    start_xfer(8'h00);
    wait_done();
    chk("div3_resp", {24'd0, spi_response}, 32'h00);
    tick();
    chk("div3_busy_cycles", busy_cnt - b0, 272);
    chk("div3_toggles", tog_cnt - t0, 16);
    chk("div3_half_period", gap, 16);

    // Second trigger while busy, then a trigger in the DONE cycle
    csr[5:4] = 2'b00;
    loop_en = 1'b1;
    tick(); tick();
    snap();
    start_xfer(8'h11);
    repeat (9) tick();
    trig = 1'b1; cmd = 8'h22;
    tick();
    trig = 1'b0;
    wait_done();
    chk("busytrig_resp", {24'd0, spi_response}, 32'h11);
    trig = 1'b1; cmd = 8'h77;
    tick();
    trig = 1'b0;
    chk("done_cycle_trig_ignored", {31'd0, spi_busy}, 0);
    repeat (40) tick();
    chk("busytrig_mosi_seq", {24'd0, mosi_log[7:0]}, 32'h11);
    chk("busytrig_done_pulses", done_cnt - d0, 1);
    chk("busytrig_busy_cycles", busy_cnt - b0, 34);

    // Reset at edge 7 of a 0x5A transfer, chip select asserted
    csr[2] = 1'b0;
    tick();
    snap();
    start_xfer(8'h5A);
    begin
      int n = 0;
      while ((tog_cnt - t0) < 7 && n < 200) begin
        tick();
        n++;
      end
    end
    chk("rst_edge7_reached", tog_cnt - t0, 7);
    chk("rst_sck_before", {31'd0, sck}, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_sck",  {31'd0, sck}, 0);
    chk("midrst_busy", {31'd0, spi_busy}, 0);
    chk("midrst_cs_n", {31'd0, cs_n}, 1);
    chk("midrst_resp", {24'd0, spi_response}, 0);
    chk("midrst_done", {31'd0, spi_done}, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_cs_n", {31'd0, cs_n}, 0);
    snap();
    start_xfer(8'h5A);
    wait_done();
    chk("post_rst_resp", {24'd0, spi_response}, 32'h5A);
    tick();
    chk("post_rst_done_pulses", done_cnt - d0, 1);
    chk("post_rst_mosi_seq", {24'd0, mosi_log[7:0]}, 32'h5A);

    // Chip select toggling in IDLE and mid-transfer
    csr[2] = 1'b1;
    chk("cs_idle_latency", {31'd0, cs_n}, 0);
    tick();
    chk("cs_idle_rise", {31'd0, cs_n}, 1);
    csr[2] = 1'b0;
    tick();
    chk("cs_idle_fall", {31'd0, cs_n}, 0);
    snap();
    start_xfer(8'h96);
    repeat (5) tick();
    csr[2] = 1'b1;
    tick();
    chk("cs_mid_rise", {31'd0, cs_n}, 1);
    csr[2] = 1'b0;
    tick();
    chk("cs_mid_fall", {31'd0, cs_n}, 0);
    wait_done();
    chk("cs_mid_resp", {24'd0, spi_response}, 32'h96);
    tick();
    chk("cs_mid_mosi_seq", {24'd0, mosi_log[7:0]}, 32'h96);
    chk("cs_mid_busy_cycles", busy_cnt - b0, 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
